// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: ALU select codes, RV32I opcode/funct constants, issue payload struct and funct3-to-select helper
package rv_alu_pkg;
  typedef enum logic [3:0] {
    SEL_ADD  = 4'b0000,
    SEL_SUB  = 4'b0001,
    SEL_XOR  = 4'b0010,
    SEL_OR   = 4'b0011,
    SEL_AND  = 4'b0100,
    SEL_SLT  = 4'b0101,
    SEL_SLTU = 4'b0110,
    SEL_SLL  = 4'b0111,
    SEL_SRL  = 4'b1000,
    SEL_SRA  = 4'b1001,
    SEL_PASS = 4'b1111
  } alu_sel_t;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    alu_sel_t    alu_sel;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } issue_t;
  localparam issue_t ISSUE_RST = '{op_a: '0, op_b: '0, alu_sel: SEL_PASS, rd: '0, rd_we: 1'b0, illegal: 1'b0};
  function automatic alu_sel_t f3_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? SEL_SUB : SEL_ADD;
      F3_SLL:  return SEL_SLL;
      F3_SLT:  return SEL_SLT;
      F3_SLTU: return SEL_SLTU;
      F3_XOR:  return SEL_XOR;
      F3_SR:   return alt ? SEL_SRA : SEL_SRL;
      F3_OR:   return SEL_OR;
      default: return SEL_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv_alu_issue_skid.sv
// rv_skid_buffer: 2-entry valid/ready skid buffer; in side (in_valid/in_ready/in_data) -> main entry drives out side (out_valid/out_ready/out_data)
module rv_skid_buffer #(
  parameter int W = 8,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] skid_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= RST;
      in_ready  <= 1'b1;
      skid_d    <= RST;
    end else if (!in_ready) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_data  <= skid_d;
        in_ready  <= 1'b1;
      end
    end else if (in_valid && (!out_valid || out_ready)) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (in_valid) begin
      skid_d   <= in_data;
      in_ready <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: rtl/rv_alu_issue.sv
// rv_alu_issue: RV32I decode/issue; in_valid/in_ready + in_instr/in_pc/in_rs1/in_rs2 -> out_valid/out_ready + op_a/op_b/alu_sel/rd/rd_we/illegal
module rv_alu_issue
  import rv_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [3:0]      alu_sel,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);
  issue_t dec, iss;
  function automatic issue_t decode(input logic [31:0] i, pc, rs1, rs2);
    issue_t d;
    logic sh;
    sh = i[14:12] == F3_SLL || i[14:12] == F3_SR;
    d = ISSUE_RST;
    d.rd = i[11:7];
    d.illegal = 1'b1;
    case (i[6:0])
      OPC_OP: begin
        d.op_a    = rs1;
        d.op_b    = sh ? {{(XLEN-SHAMT_W){1'b0}}, rs2[SHAMT_W-1:0]} : rs2;
        d.alu_sel = f3_sel(i[14:12], i[30]);
        d.illegal = !(i[31:25] == F7_BASE || (i[31:25] == F7_ALT && (i[14:12] == F3_ADD || i[14:12] == F3_SR)));
      end
      OPC_OP_IMM: begin
        d.op_a    = rs1;
        d.op_b    = sh ? {{(XLEN-SHAMT_W){1'b0}}, i[20+:SHAMT_W]} : {{20{i[31]}}, i[31:20]};
        d.alu_sel = f3_sel(i[14:12], i[14:12] == F3_SR && i[30]);
        d.illegal = sh && !(i[31:25] == F7_BASE || (i[31:25] == F7_ALT && i[14:12] == F3_SR));
      end
      OPC_LUI: begin
        d.op_a    = {i[31:12], 12'b0};
        d.illegal = 1'b0;
      end
      OPC_AUIPC: begin
        d.op_a    = pc;
        d.op_b    = {i[31:12], 12'b0};
        d.alu_sel = SEL_ADD;
        d.illegal = 1'b0;
      end
      default: ;
    endcase
    if (d.illegal) begin
      d.op_a    = '0;
      d.op_b    = '0;
      d.alu_sel = SEL_PASS;
    end
    d.rd_we = !d.illegal && i[11:7] != 5'd0;
    return d;
  endfunction
  assign dec = decode(in_instr, in_pc, in_rs1, in_rs2);
  rv_skid_buffer #(.W($bits(issue_t)), .RST(ISSUE_RST)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (iss)
  );
  assign op_a    = iss.op_a;
  assign op_b    = iss.op_b;
  assign alu_sel = iss.alu_sel;
  assign rd      = iss.rd;
  assign rd_we   = iss.rd_we;
  assign illegal = iss.illegal;
endmodule
